// File: rtl/usb_gpx_pkg.sv
// Shared defaults and types for the MAX3421E GPX pin conditioner.
package usb_gpx_pkg;

  localparam int GPX_SYNC_STAGES_DEF   = 2;
  localparam int GPX_FILTER_CYCLES_DEF = 8;
  localparam int GPX_EVT_CNT_W_DEF     = 16;

  typedef struct packed {
    logic rise;
    logic fall;
  } gpx_edge_t;

endpackage

// File: rtl/usb_gpx_conditioner_if.sv
// GPX pin / software-facing signal bundle; slave is the conditioner side, master the pin and PIO side.
interface usb_gpx_if import usb_gpx_pkg::*; #(
  parameter int EVT_CNT_W = GPX_EVT_CNT_W_DEF
);

  logic                 gpx_pin;
  logic                 evt_clr;
  logic                 gpx_out;
  logic                 gpx_rise;
  logic                 gpx_fall;
  logic                 gpx_evt;
  logic [EVT_CNT_W-1:0] evt_count;

  modport slave (
    input  gpx_pin, evt_clr,
    output gpx_out, gpx_rise, gpx_fall, gpx_evt, evt_count
  );

  modport master (
    output gpx_pin, evt_clr,
    input  gpx_out, gpx_rise, gpx_fall, gpx_evt, evt_count
  );

endinterface

// File: rtl/usb_gpx_sync.sv
// Plain flop-chain synchroniser for an asynchronous single-bit input (also used for the USB IRQ pin).
module usb_gpx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner: synchronise, glitch-filter, edge pulses, sticky event flag.
// Define USB_GPX_EDGE_COUNT_EN to build the saturating filtered-edge counter on evt_count.
module usb_gpx_conditioner import usb_gpx_pkg::*; #(
  parameter int SYNC_STAGES   = GPX_SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = GPX_FILTER_CYCLES_DEF,
  parameter int EVT_CNT_W     = GPX_EVT_CNT_W_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  usb_gpx_if.slave  gpx
);

  localparam int                FCNT_W    = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);

  logic              s_in;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              out_q, out_d;
  gpx_edge_t         edge_q, edge_d;
  logic              evt_q, evt_d;
  logic              edge_seen;

  usb_gpx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (gpx.gpx_pin),
    .dout    (s_in)
  );

  // Any disagreement must persist FILTER_CYCLES consecutive cycles; one agreeing sample restarts it.
  always_comb begin
    fcnt_d = fcnt_q;
    out_d  = out_q;
    edge_d = '0;
    if (s_in == out_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      out_d       = s_in;
      fcnt_d      = '0;
      edge_d.rise = s_in;
      edge_d.fall = ~s_in;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Flag follows the visible pulse, so a clear coinciding with a pulse loses to the set.
  assign edge_seen = edge_q.rise | edge_q.fall;

  always_comb begin
    evt_d = evt_q;
    if (gpx.evt_clr) evt_d = 1'b0;
    if (edge_seen)   evt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
      out_q  <= 1'b0;
      edge_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      out_q  <= out_d;
      edge_q <= edge_d;
      evt_q  <= evt_d;
    end
  end

  assign gpx.gpx_out  = out_q;
  assign gpx.gpx_rise = edge_q.rise;
  assign gpx.gpx_fall = edge_q.fall;
  assign gpx.gpx_evt  = evt_q;

`ifdef USB_GPX_EDGE_COUNT_EN
  logic [EVT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (gpx.evt_clr)                   cnt_d = edge_seen ? EVT_CNT_W'(1) : '0;
    else if (edge_seen && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign gpx.evt_count = cnt_q;
`else
  assign gpx.evt_count = '0;
`endif

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed bench for usb_gpx_conditioner; expected filtered edges are queued with their due cycle.
module tb_usb_gpx_conditioner;
  import usb_gpx_pkg::*;

  localparam int SYNC    = 2;
  localparam int FILT    = 8;
  localparam int CW      = 4;
  localparam int LAT     = SYNC + FILT;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic rise;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  logic prev_out = 1'b0;
  exp_t q[$];

  usb_gpx_if #(.EVT_CNT_W(CW)) bus ();

  usb_gpx_conditioner #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .EVT_CNT_W     (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gpx     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef USB_GPX_EDGE_COUNT_EN
    return 32'(model_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step_pin(input logic v);
    @(posedge clk);
    #1;
    bus.gpx_pin = v;
  endtask

  task automatic expect_edge(input logic r, input int due);
    q.push_back('{r, due});
    if (model_cnt < CNT_MAX) model_cnt++;
  endtask

  task automatic chk_outs(input string tag, input logic out, input logic evt);
    check({tag, "_out"}, 32'(bus.gpx_out), 32'(out));
    check({tag, "_evt"}, 32'(bus.gpx_evt), 32'(evt));
    check({tag, "_cnt"}, 32'(bus.evt_count), exp_cnt());
  endtask

  // Edge monitor: every pulse or level change must match the head of the queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_out = 1'b0;
    end else begin
      if (bus.gpx_rise || bus.gpx_fall || bus.gpx_out !== prev_out) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_edge: observed rise=%0b fall=%0b out=%0b expected no edge at cycle %0d",
                 bus.gpx_rise, bus.gpx_fall, bus.gpx_out, cyc);
        end
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("edge_pulses", 32'({bus.gpx_rise, bus.gpx_fall}), e.rise ? 32'd2 : 32'd1);
          check("edge_level", 32'(bus.gpx_out), 32'(e.rise));
          check("edge_due_cycle", (cyc >= e.due - 1 && cyc <= e.due + 1) ? 32'(cyc) : 32'hFFFF_FFFF,
                32'(cyc));
        end
      end
      prev_out = bus.gpx_out;
    end
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    bus.gpx_pin = 1'b0;
    bus.evt_clr = 1'b0;

    // Reset state, then idle with pin low
    repeat (3) @(posedge clk);
    #1;
    check("rst_rise", 32'(bus.gpx_rise), 32'd0);
    check("rst_fall", 32'(bus.gpx_fall), 32'd0);
    chk_outs("rst", 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk_outs("idle", 1'b0, 1'b0);

    // Clean rise
    step_pin(1'b1);
    expect_edge(1'b1, cyc + LAT);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("rise_not_early", 32'(bus.gpx_out), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_outs("rise", 1'b1, 1'b1);

    // Back to low, clear the flag
    step_pin(1'b0);
    expect_edge(1'b0, cyc + LAT);
    repeat (15) @(posedge clk);
    @(negedge clk);
    bus.evt_clr = 1'b1;
    @(negedge clk);
    bus.evt_clr = 1'b0;
    model_cnt   = 0;
    chk_outs("clr_alone", 1'b0, 1'b0);

    // 1-cycle and 7-cycle glitches are rejected
    step_pin(1'b1);
    step_pin(1'b0);
    repeat (14) @(posedge clk);
    step_pin(1'b1);
    repeat (6) @(posedge clk);
    step_pin(1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk_outs("glitch", 1'b0, 1'b0);

    // 8-cycle pulse is just long enough
    step_pin(1'b1);
    expect_edge(1'b1, cyc + LAT);
    repeat (7) @(posedge clk);
    step_pin(1'b0);
    expect_edge(1'b0, cyc + LAT);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk_outs("pulse8", 1'b0, 1'b1);

    // Bounce restarts the stable interval
    step_pin(1'b1);
    repeat (4) @(posedge clk);
    step_pin(1'b0);
    step_pin(1'b1);
    expect_edge(1'b1, cyc + LAT);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk_outs("bounce", 1'b1, 1'b1);

    // Clear coinciding with a fall pulse: set wins
    step_pin(1'b0);
    expect_edge(1'b0, cyc + LAT);
    @(negedge clk);
    n = 0;
    while (!bus.gpx_fall && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("fall_seen", 32'(bus.gpx_fall), 32'd1);
    bus.evt_clr = 1'b1;
    @(negedge clk);
    bus.evt_clr = 1'b0;
    model_cnt   = 1;
    chk_outs("clr_with_edge", 1'b0, 1'b1);

    // Clear alone, then 20 clean toggles to saturate the counter
    repeat (3) @(negedge clk);
    bus.evt_clr = 1'b1;
    @(negedge clk);
    bus.evt_clr = 1'b0;
    model_cnt   = 0;
    chk_outs("clr2", 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step_pin(~bus.gpx_pin);
      expect_edge(bus.gpx_pin, cyc + LAT);
      repeat (11) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_model", 32'(model_cnt), 32'(CNT_MAX));
    chk_outs("sat", 1'b0, 1'b1);

    // Reset mid-filter with pin high, then full-latency rise after release
    step_pin(1'b1);
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    q.delete();
    model_cnt = 0;
    #1;
    check("midrst_rise", 32'(bus.gpx_rise), 32'd0);
    check("midrst_fall", 32'(bus.gpx_fall), 32'd0);
    chk_outs("midrst", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    expect_edge(1'b1, cyc + LAT);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk_outs("post_rst", 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    check("pending_edges", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
